// File: rtl/product_bcd_converter_pkg.sv
// Shared definitions for the multiplier display path: product/BCD widths and
// the converter FSM state encoding.
package product_bcd_converter_pkg;

    localparam int PRODUCT_W  = 15;
    localparam int BCD_DIGITS = 5;
    localparam int CNT_WIDTH  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } conv_state_t;

endpackage

// File: rtl/product_bcd_converter_if.sv
// Handshake and result bundle between the converter and its producer/consumer.
interface product_bcd_converter_if
    import product_bcd_converter_pkg::*;
#(
    parameter int IN_W   = PRODUCT_W,
    parameter int DIGITS = BCD_DIGITS
);
    logic                  start;
    logic [IN_W-1:0]       bin_in;
    logic                  sign_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  sign_out;
    logic [DIGITS-1:0]     lz_mask;

    modport master (
        output start, bin_in, sign_in,
        input  busy, done, bcd_out, sign_out, lz_mask
    );

    modport slave (
        input  start, bin_in, sign_in,
        output busy, done, bcd_out, sign_out, lz_mask
    );
endinterface

// File: rtl/product_bcd_converter_add3.sv
// Double-dabble correction cell: adds 3 to a BCD nibble of 5 or more so the
// following left shift carries correctly into the next decimal digit.
module product_bcd_converter_add3 (
    input  logic [3:0] nib_in,
    output logic [3:0] nib_out
);
    assign nib_out = (nib_in >= 4'd5) ? nib_in + 4'd3 : nib_in;
endmodule

// File: rtl/product_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock,
// with registered BCD digits, sign and leading-zero mask for the display stage.
module product_bcd_converter
    import product_bcd_converter_pkg::*;
#(
    parameter int IN_W   = PRODUCT_W,
    parameter int DIGITS = BCD_DIGITS,
    parameter int CNT_W  = CNT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    product_bcd_converter_if.slave   bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int SH_W  = BCD_W + IN_W;
    localparam logic [DIGITS-1:0] LZ_RESET = {{(DIGITS-1){1'b1}}, 1'b0};

    conv_state_t        state_q, state_d;
    logic [SH_W-1:0]    sh_q, sh_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sign_lat_q, sign_lat_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               sign_out_q, sign_out_d;
    logic [DIGITS-1:0]  lz_q, lz_d;

    logic [BCD_W-1:0]   adj;
    logic [SH_W-1:0]    shifted;
    logic [BCD_W-1:0]   new_bcd;
    logic [DIGITS-1:0]  lz_calc;
    logic               zero_run;
    logic               last_bit;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
            product_bcd_converter_add3 u_add3 (
                .nib_in  (sh_q[IN_W + 4*gi +: 4]),
                .nib_out (adj[4*gi +: 4])
            );
        end
    endgenerate

    // Shift in SH_W context so the (always zero) top BCD bit falls off.
    assign shifted  = {adj, sh_q[IN_W-1:0]} << 1;
    assign new_bcd  = shifted[SH_W-1 -: BCD_W];
    assign last_bit = (cnt_q == CNT_W'(IN_W - 1));

    // A digit is a leading zero when it and every more significant digit are zero.
    always_comb begin
        lz_calc  = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run   = zero_run & (new_bcd[4*i +: 4] == 4'd0);
            lz_calc[i] = zero_run;
        end
    end

    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        cnt_d      = cnt_q;
        sign_lat_d = sign_lat_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        bcd_d      = bcd_q;
        sign_out_d = sign_out_q;
        lz_d       = lz_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    sh_d       = {{BCD_W{1'b0}}, bus.bin_in};
                    sign_lat_d = bus.sign_in & (|bus.bin_in);
                    cnt_d      = '0;
                    busy_d     = 1'b1;
                    state_d    = ST_CONV;
                end
            end
            ST_CONV: begin
                sh_d  = shifted;
                cnt_d = cnt_q + 1'b1;
                if (last_bit) begin
                    bcd_d      = new_bcd;
                    lz_d       = lz_calc;
                    sign_out_d = sign_lat_q;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sh_q       <= '0;
            cnt_q      <= '0;
            sign_lat_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            sign_out_q <= 1'b0;
            lz_q       <= LZ_RESET;
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            cnt_q      <= cnt_d;
            sign_lat_q <= sign_lat_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bcd_q      <= bcd_d;
            sign_out_q <= sign_out_d;
            lz_q       <= lz_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.bcd_out  = bcd_q;
    assign bus.sign_out = sign_out_q;
    assign bus.lz_mask  = lz_q;

endmodule

// File: tb/tb_product_bcd_converter.sv
// Randomized and directed checks of the BCD converter against a decimal
// arithmetic reference model.
module tb_product_bcd_converter;
    import product_bcd_converter_pkg::*;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    product_bcd_converter_if bus ();

    product_bcd_converter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int pow10(input int n);
        int p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [19:0] model_bcd(input int v);
        logic [19:0] r = '0;
        for (int i = 0; i < 5; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
        return r;
    endfunction

    function automatic logic [4:0] model_lz(input int v);
        logic [4:0] m = '0;
        for (int i = 1; i < 5; i++) m[i] = (v < pow10(i));
        return m;
    endfunction

    // Start a conversion, wait for done, and compare everything it should produce.
    task automatic run_conv(input int v, input bit s);
        int  k;
        bit  got_done;
        bit  busy_bad;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.bin_in  = 15'(v);
        bus.sign_in = s;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        got_done  = 1'b0;
        busy_bad  = 1'b0;
        k         = 0;
        while (!got_done && k < 40) begin
            @(posedge clk);
            #1;
            k++;
            if (bus.done) got_done = 1'b1;
            else if (!bus.busy) busy_bad = 1'b1;
        end
        check("done_seen", 32'(got_done), 32'd1);
        check("latency", 32'(k), 32'd15);
        check("busy_held", 32'(busy_bad), 32'd0);
        check("busy_at_done", 32'(bus.busy), 32'd0);
        check("bcd_out", 32'(bus.bcd_out), 32'(model_bcd(v)));
        check("lz_mask", 32'(bus.lz_mask), 32'(model_lz(v)));
        check("sign_out", 32'(bus.sign_out), 32'(s && v != 0));
        @(posedge clk);
        #1;
        check("done_pulse", 32'(bus.done), 32'd0);
        $display("conv bin=%0d sign=%0d -> bcd=%05h sign_out=%0d lz=%05b",
                 v, s, bus.bcd_out, bus.sign_out, bus.lz_mask);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check({tag, "_bcd"}, 32'(bus.bcd_out), 32'd0);
        check({tag, "_sign"}, 32'(bus.sign_out), 32'd0);
        check({tag, "_lz"}, 32'(bus.lz_mask), 32'b11110);
    endtask

    initial begin
        int  ndone;
        bit  early;
        int  cyc;
        int  n;
        int  vals[3];
        int  done_cyc[3];

        n_total     = 0;
        n_bad       = 0;
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.bin_in  = '0;
        bus.sign_in = 1'b0;
        #12;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Zero with negative sign, then the range boundaries.
        run_conv(0, 1'b1);
        run_conv(16384, 1'b0);
        run_conv(16256, 1'b1);
        run_conv(9, 1'b0);
        run_conv(12345, 1'b0);
        run_conv(32767, 1'b1);

        // A start pulse during conversion must be ignored.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bin_in = 15'd42;
        bus.sign_in = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        ndone = 0;
        early = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                ndone++;
                check("ignore_bcd", 32'(bus.bcd_out), 32'(model_bcd(42)));
            end
            if (k < 15 && !bus.busy) early = 1'b1;
            if (k == 3) begin
                bus.start  = 1'b1;
                bus.bin_in = 15'd99;
            end
            if (k == 4) bus.start = 1'b0;
        end
        check("ignore_ndone", 32'(ndone), 32'd1);
        check("ignore_busy", 32'(early), 32'd0);
        $display("ignore-start: dones=%0d bcd=%05h", ndone, bus.bcd_out);

        // Reset in the middle of a conversion.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bin_in = 15'd500;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        ndone = 0;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) ndone++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        check("midrst_nodone", 32'(ndone), 32'd0);
        $display("mid-conversion reset: outputs bcd=%05h lz=%05b", bus.bcd_out, bus.lz_mask);
        @(negedge clk);
        rst_n = 1'b1;
        run_conv(77, 1'b0);

        // Start held high: one result every IN_W+2 cycles, in order.
        vals[0] = 1; vals[1] = 2; vals[2] = 3;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.bin_in  = 15'(vals[0]);
        bus.sign_in = 1'b0;
        cyc = 0;
        n   = 0;
        while (n < 3 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.done) begin
                done_cyc[n] = cyc;
                check("b2b_bcd", 32'(bus.bcd_out), 32'(model_bcd(vals[n])));
                $display("back-to-back result %0d at cycle %0d: bcd=%05h", n, cyc, bus.bcd_out);
                n++;
                if (n < 3) bus.bin_in = 15'(vals[n]);
                else bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        check("b2b_count", 32'(n), 32'd3);
        if (n == 3) begin
            check("b2b_first", 32'(done_cyc[0]), 32'd16);
            check("b2b_gap1", 32'(done_cyc[1] - done_cyc[0]), 32'd17);
            check("b2b_gap2", 32'(done_cyc[2] - done_cyc[1]), 32'd17);
        end
        @(posedge clk);
        @(posedge clk);

        // Random magnitudes and signs.
        for (int t = 0; t < 40; t++) begin
            int v;
            bit s;
            v = int'($urandom_range(0, 32767));
            if (t % 10 == 0) v = int'($urandom_range(0, 120));
            s = bit'($urandom_range(0, 1));
            run_conv(v, s);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
